// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART receive controller slice.
package uart_pkg;

    typedef enum logic [1:0] {
        OFF = 2'd0,
        ARM = 2'd1,
        RUN = 2'd2
    } rx_state_t;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_DIV_WIDTH  = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_ARM_CYCLES = 2;
    localparam int unsigned OVERSAMPLE     = 16;

endpackage

// File: rtl/uart_baud_gen.sv
// Oversampling tick generator: one-cycle s_tick every max(divisor,1) cycles while run is high.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = DEF_DIV_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 run,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 s_tick
);

    logic [DIV_WIDTH-1:0] cnt;
    logic [DIV_WIDTH-1:0] term;
    logic [DIV_WIDTH-1:0] term_new;
    logic                 wrap;

    always_comb begin
        term_new = (divisor == '0) ? '0 : divisor - DIV_WIDTH'(1);
        wrap     = (cnt == term);
        s_tick   = run && wrap;
    end

    // Terminal value is latched only at the wrap, so the running count can
    // never overshoot a smaller divisor written mid-period.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            term <= '0;
        end else if (!run) begin
            cnt  <= '0;
            term <= term_new;
        end else if (wrap) begin
            cnt  <= '0;
            term <= term_new;
        end else begin
            cnt  <= cnt + DIV_WIDTH'(1);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enable sequencing, baud tick, done-edge capture into a
// small FIFO with valid/ready read side and sticky overrun.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DIV_WIDTH  = DEF_DIV_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned ARM_CYCLES = DEF_ARM_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DIV_WIDTH-1:0]          divisor,
    input  logic [DATA_WIDTH-1:0]         rx_data,
    input  logic                          rx_done_tick,
    output logic                          s_tick,
    output logic                          rcv_reset_n,
    output logic [DATA_WIDTH-1:0]         m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          overrun,
    input  logic                          clear_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;

    rx_state_t             state;
    rx_state_t             state_next;
    logic [AW-1:0]         arm_cnt;
    logic                  arm_done;
    logic                  run;

    logic                  done_q;
    logic                  push_evt;
    logic                  pop;
    logic                  full;
    logic                  do_push;
    logic                  drop;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [LW-1:0]         count;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= OFF;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state != ARM) begin
            arm_cnt <= '0;
        end else begin
            arm_cnt <= arm_cnt + AW'(1);
        end
    end

    always_comb begin
        arm_done    = (arm_cnt == AW'(ARM_CYCLES - 1));
        state_next  = state;
        rcv_reset_n = 1'b0;
        unique case (state)
            OFF: begin
                if (enable) state_next = ARM;
            end
            ARM: begin
                if (!enable)       state_next = OFF;
                else if (arm_done) state_next = RUN;
            end
            RUN: begin
                rcv_reset_n = 1'b1;
                if (!enable) state_next = OFF;
            end
            default: state_next = OFF;
        endcase
    end

    always_comb run = (state == RUN);

    uart_baud_gen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_baud_gen (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .divisor (divisor),
        .s_tick  (s_tick)
    );

    // Edge history is wiped outside RUN so a level already high at entry
    // still yields one capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= run ? rx_done_tick : 1'b0;
        end
    end

    always_comb begin
        m_valid  = (count != '0);
        full     = (count == LW'(FIFO_DEPTH));
        push_evt = run && rx_done_tick && !done_q;
        pop      = m_valid && m_ready;
        do_push  = push_evt && (!full || pop);
        drop     = push_evt && full && !pop;
        m_data   = m_valid ? mem[rd_ptr] : '0;
        fifo_level = count;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clear_overrun) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller that sequences the UART receiver datapath.
- Generates the oversampling tick (s_tick) from a programmable divisor.
- Holds the receiver in reset while disabled or re-arming.
- Captures each completed byte into a small FIFO, read through a valid/ready interface.
- Flags overrun when a byte arrives with the FIFO full.
- Sits between the receiver instance and the host/bus side.

Parameters:
- DATA_WIDTH, 8, width of received byte; must match the receiver instance.
- DIV_WIDTH, 16, width of the baud divisor.
- FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2.
- ARM_CYCLES, 2, cycles the receiver reset is held after enable rises.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  receive enable; level.
- divisor  in  DIV_WIDTH  clk cycles per s_tick; 0 is treated as 1.
- rx_data  in  DATA_WIDTH  receiver byte output.
- rx_done_tick  in  1  receiver done flag. Treated as a level; capture occurs on its 0->1 edge.
- s_tick  out  1  one-cycle oversampling tick to the receiver.
- rcv_reset_n  out  1  active-low reset to the receiver.
- m_data  out  DATA_WIDTH  FIFO head byte.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  consumer accepts the head byte when m_valid and m_ready are both high.
- overrun  out  1  sticky: a byte was dropped.
- clear_overrun  in  1  clears overrun.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  occupied entries.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset). All state updates on posedge clk.
- Reset values: state=OFF, s_tick=0, rcv_reset_n=0, m_valid=0, m_data=0, overrun=0, fifo_level=0, tick counter=0, done edge register=0.
- FSM states: OFF, ARM, RUN.
  - OFF: rcv_reset_n=0, tick counter held at 0, no captures. enable=1 -> ARM.
  - ARM: rcv_reset_n=0 for ARM_CYCLES cycles, counted by arm counter. enable=0 -> OFF. Count done -> RUN.
  - RUN: rcv_reset_n=1, tick generator active, captures enabled. enable=0 -> OFF the next cycle.
- Leaving RUN for OFF is immediate; an in-flight byte is abandoned.
- FIFO contents, m_valid and overrun are preserved across OFF/ARM and stay readable.
- Tick generator:
  - Counter runs 0..max(divisor,1)-1.
  - s_tick=1 for exactly the cycle in which counter==max(divisor,1)-1, then the counter wraps to 0.
  - divisor=1 or 0: s_tick is high every RUN cycle.
  - A divisor change is sampled at the wrap only. If the counter already exceeds the new terminal value, it is used from the next wrap with no extra tick.
- Capture:
  - done_q registers rx_done_tick every cycle; done_q is cleared in OFF/ARM.
  - Push condition: RUN and rx_done_tick=1 and done_q=0. rx_data is written on that cycle.
  - A level held high across many cycles produces exactly one push.
- FIFO:
  - Write/read pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Occupancy counter is one bit wider.
  - Push to an empty FIFO gives m_valid=1 the next cycle (latency 1), with m_data equal to the pushed byte.
  - Pop when m_valid and m_ready; m_data is the new head the following cycle.
  - m_ready with m_valid=0 has no effect.
  - Push and pop in the same cycle with level unchanged: both occur, including at full and at level 1.
  - Push when full without a simultaneous pop: byte dropped, overrun=1 the next cycle, FIFO unchanged.
- Overrun:
  - Set on a drop event.
  - clear_overrun clears it.
  - A simultaneous drop event and clear leaves it set (set wins).
- Reset mid-operation: every register returns to its reset value the next cycle, including FIFO pointers; contents become invalid.

Decomposition:
- Package uart_pkg: FSM state encoding (OFF=2'd0, ARM=2'd1, RUN=2'd2), default DATA_WIDTH/DIV_WIDTH/FIFO_DEPTH constants, oversampling ratio constant 16.
- Sub-module uart_baud_gen:
  - Inputs: divisor, run.
  - Output: s_tick.
  - Holds the counter and the wrap-time divisor sampling.
- FIFO and FSM stay in uart_rx_ctrl.

Test Plan:
- Reset, then enable=1, divisor=27 -> rcv_reset_n low for 2 cycles after ARM entry, then high. First s_tick on the 27th RUN cycle, then every 27 cycles.
- divisor=0, then divisor=1 in RUN -> s_tick high every cycle in both cases. Change divisor 27->5 mid-count -> 27-cycle period completes, then 5-cycle period.
- Drive rx_data=8'hA5 with rx_done_tick high for 40 cycles, m_ready=0 -> exactly one push; m_valid=1 one cycle later; m_data=8'hA5; fifo_level=1.
- Push 5 bytes 8'h01..8'h05 with m_ready=0, FIFO_DEPTH=4 -> fifo_level=4, overrun=1, 8'h05 dropped. Drain -> 01,02,03,04 in order, then m_valid=0.
- At full, push 8'h06 with m_ready=1 in the same cycle -> no overrun; level stays 4; head advances. Drop event with clear_overrun=1 in the same cycle -> overrun remains 1.
- Push 8'h3C, drop enable while a second byte is in flight -> OFF next cycle; rcv_reset_n=0; 8'h3C still readable. Then assert reset -> m_valid=0, fifo_level=0, overrun=0.
